// File: rtl/clock_reset_sequencer_pkg.sv
// clock_reset_pkg: shared state encoding, counter sizing and default timing for the reset sequencer
package clock_reset_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    REL_IC,
    RUN
  } state_e;

  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_LOCK_FILTER_CYCLES  = 4;
  localparam int DEF_MIN_ASSERT_CYCLES   = 16;
  localparam int DEF_IC_TO_PERIPH_CYCLES = 8;

  // Bits needed to hold values 0..max(a,b) without wrapping
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction

endpackage

// File: rtl/clock_reset_sequencer_sync.sv
// reset_sync_ff: N-stage synchronizer with asynchronous active-low clear to 0
module reset_sync_ff #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  // Shift the asynchronous input through N flops; clearing reads as "not ready"
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[N-2:0], d_i};

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/clock_reset_sequencer.sv
// clock_reset_sequencer: per-domain ordered reset release gated by filtered lock and external request
module clock_reset_sequencer
  import clock_reset_pkg::*;
#(
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int LOCK_FILTER_CYCLES  = DEF_LOCK_FILTER_CYCLES,
  parameter int MIN_ASSERT_CYCLES   = DEF_MIN_ASSERT_CYCLES,
  parameter int IC_TO_PERIPH_CYCLES = DEF_IC_TO_PERIPH_CYCLES
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_ext_resetn,
  input  logic i_locked,
  output logic o_interconnect_resetn,
  output logic o_peripheral_resetn,
  output logic o_peripheral_reset,
  output logic o_in_reset
);

  localparam int CW = cnt_width(MIN_ASSERT_CYCLES, IC_TO_PERIPH_CYCLES);
  localparam int LW = cnt_width(LOCK_FILTER_CYCLES, 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] IC_LAST  = CW'(IC_TO_PERIPH_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FILTER_CYCLES);

  logic          req_n_s, lock_s, lock_ok, go;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_e        state_q, state_d;
  logic          ic_n_d, pr_n_d, pr_d, in_rst_d;

  reset_sync_ff #(.N(SYNC_STAGES)) u_req_sync (
    .clk_i (i_clk),
    .rst_ni(i_resetn),
    .d_i   (i_ext_resetn),
    .q_o   (req_n_s)
  );

  reset_sync_ff #(.N(SYNC_STAGES)) u_lock_sync (
    .clk_i (i_clk),
    .rst_ni(i_resetn),
    .d_i   (i_locked),
    .q_o   (lock_s)
  );

  assign lock_ok = lock_cnt_q == LOCK_MAX;
  assign go      = req_n_s && lock_ok;

  // Lock filter: count consecutive locked cycles, saturate, drop to zero on any unlock
  always_comb lock_cnt_d = !lock_s ? '0 : lock_ok ? lock_cnt_q : lock_cnt_q + 1'b1;

  // Next-state decode; losing go aborts from any released state, outputs follow the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ASSERT: begin
        state_d = (go && cnt_q == MIN_LAST) ? REL_IC : ASSERT;
        cnt_d   = (!go || cnt_q == MIN_LAST) ? '0 : cnt_q + 1'b1;
      end
      REL_IC: begin
        state_d = !go ? ASSERT : (cnt_q == IC_LAST) ? RUN : REL_IC;
        cnt_d   = (!go || cnt_q == IC_LAST) ? '0 : cnt_q + 1'b1;
      end
      RUN:     state_d = go ? RUN : ASSERT;
      default: state_d = ASSERT;
    endcase
    ic_n_d   = state_d != ASSERT;
    pr_n_d   = state_d == RUN;
    pr_d     = state_d != RUN;
    in_rst_d = state_d != RUN;
  end

  // State, counters and glitch-free registered outputs
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      state_q               <= ASSERT;
      cnt_q                 <= '0;
      lock_cnt_q            <= '0;
      o_interconnect_resetn <= 1'b0;
      o_peripheral_resetn   <= 1'b0;
      o_peripheral_reset    <= 1'b1;
      o_in_reset            <= 1'b1;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      lock_cnt_q            <= lock_cnt_d;
      o_interconnect_resetn <= ic_n_d;
      o_peripheral_resetn   <= pr_n_d;
      o_peripheral_reset    <= pr_d;
      o_in_reset            <= in_rst_d;
    end

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb_clock_reset_sequencer: directed timeline checks of the reset sequencer with default timing
module tb_clock_reset_sequencer;

  logic clk = 1'b0;
  logic rst_n, ext_n, locked;
  logic ic_n, pr_n, pr, in_rst;
  int   total = 0;
  int   bad = 0;

  localparam logic [3:0] HELD = 4'b0011;
  localparam logic [3:0] ICUP = 4'b1011;
  localparam logic [3:0] RUNV = 4'b1100;

  clock_reset_sequencer dut (
    .i_clk                (clk),
    .i_resetn             (rst_n),
    .i_ext_resetn         (ext_n),
    .i_locked             (locked),
    .o_interconnect_resetn(ic_n),
    .o_peripheral_resetn  (pr_n),
    .o_peripheral_reset   (pr),
    .o_in_reset           (in_rst)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {ic_n, pr_n, pr, in_rst};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic power_seq(input string tag);
    tick(21); chk({tag, "_e21"}, HELD);
    tick(1);  chk({tag, "_e22"}, ICUP);
    tick(7);  chk({tag, "_e29"}, ICUP);
    tick(1);  chk({tag, "_e30"}, RUNV);
  endtask

  initial begin
    rst_n  = 1'b1;
    ext_n  = 1'b1;
    locked = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("por_values", HELD);
    #9 rst_n = 1'b1;
    power_seq("pwrup");
    tick(5); chk("run_hold", RUNV);

    ext_n = 1'b0;
    tick(1); ext_n = 1'b1;
    tick(1);  chk("req_e2", RUNV);
    tick(1);  chk("req_e3", HELD);
    tick(15); chk("req_e18", HELD);
    tick(1);  chk("req_e19", ICUP);
    tick(7);  chk("req_e26", ICUP);
    tick(1);  chk("req_e27", RUNV);

    tick(3);
    ext_n = 1'b0;
    tick(1); ext_n = 1'b1;
    tick(2);  chk("glitch_asrt", HELD);
    tick(10);
    locked = 1'b0;
    tick(2); locked = 1'b1;
    tick(4);  chk("glitch_e19", HELD);
    tick(17); chk("glitch_e36", HELD);
    tick(1);  chk("glitch_e37", ICUP);
    tick(7);  chk("glitch_e44", ICUP);
    tick(1);  chk("glitch_e45", RUNV);

    tick(3);
    ext_n = 1'b0;
    tick(1); ext_n = 1'b1;
    tick(2);  chk("abort_asrt", HELD);
    tick(16); chk("abort_relic", ICUP);
    tick(3);
    locked = 1'b0;
    tick(3);  chk("abort_e25", ICUP);
    tick(1);  chk("abort_e26", HELD);
    tick(20); chk("abort_noperiph", HELD);

    locked = 1'b1;
    power_seq("relock");

    tick(2);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", HELD);
    #2 rst_n = 1'b1;
    power_seq("reseq");

    rst_n  = 1'b0;
    locked = 1'b0;
    #1 chk("nolock_rst", HELD);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(100);
      chk("nolock_hold", HELD);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
